// File: rtl/vram_arbiter.sv
// Video RAM port arbiter: renderer reads, posted CPU writes (2-deep FIFO)
// and CPU reads share one single-port RAM, with a starvation guard that
// bounds how long the renderer can hold off pending CPU work.
module vram_arbiter #(
    parameter int unsigned AW     = 12,
    parameter int unsigned DW     = 16,
    parameter int unsigned STARVE = 4
) (
    input  logic          clk,
    input  logic          rst,
    // renderer read port
    input  logic          r_req,
    input  logic [AW-1:0] r_addr,
    output logic          r_gnt,
    output logic          r_valid,
    output logic [DW-1:0] r_data,
    // CPU port
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    // RAM port
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    localparam int unsigned CNT_W = 2;
    localparam int unsigned STV_W = 3;
    localparam logic [CNT_W-1:0] FIFO_FULL  = CNT_W'(2);
    localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE);

    logic [AW-1:0]    fifoAddr [2];
    logic [DW-1:0]    fifoData [2];
    logic             wrPtr;
    logic             rdPtr;
    logic [CNT_W-1:0] fifoCount;
    logic [STV_W-1:0] starveCnt;

    logic notEmpty;
    logic notFull;
    logic cpuRead;
    logic cpuPending;
    logic rendSel;
    logic wrSel;
    logic rdSel;
    logic push;

    // Port selection: renderer first unless it has starved pending CPU work,
    // then buffered writes (keeps reads ordered behind writes), then CPU read.
    // Nothing is granted while reset is held so no RAM write can slip out.
    always_comb begin
        notEmpty   = (fifoCount != '0);
        notFull    = (fifoCount != FIFO_FULL);
        cpuRead    = c_req & ~c_we;
        cpuPending = notEmpty | cpuRead;
        rendSel    = ~rst & r_req & ((starveCnt < STARVE_MAX) | ~cpuPending);
        wrSel      = ~rst & ~rendSel & notEmpty;
        rdSel      = ~rst & ~rendSel & ~notEmpty & cpuRead;
        push       = ~rst & c_req & c_we & notFull;
    end

    // Grant and RAM port drive for the selected requester.
    always_comb begin
        r_gnt   = rendSel;
        c_gnt   = push | rdSel;
        m_en    = rendSel | wrSel | rdSel;
        m_we    = wrSel;
        m_addr  = '0;
        m_wdata = '0;
        if (rendSel) begin
            m_addr = r_addr;
        end else if (wrSel) begin
            m_addr  = fifoAddr[rdPtr];
            m_wdata = fifoData[rdPtr];
        end else if (rdSel) begin
            m_addr = c_addr;
        end
    end

    // Write FIFO storage; contents are don't-care once count is cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoAddr[wrPtr] <= c_addr;
            fifoData[wrPtr] <= c_wdata;
        end
    end

    // Write FIFO pointers and occupancy; simultaneous push/pop holds count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr     <= 1'b0;
            rdPtr     <= 1'b0;
            fifoCount <= '0;
        end else begin
            if (push)  wrPtr <= ~wrPtr;
            if (wrSel) rdPtr <= ~rdPtr;
            case ({push, wrSel})
                2'b10:   fifoCount <= fifoCount + CNT_W'(1);
                2'b01:   fifoCount <= fifoCount - CNT_W'(1);
                default: fifoCount <= fifoCount;
            endcase
        end
    end

    // Starvation counter: consecutive renderer wins while CPU work waits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starveCnt <= '0;
        end else if (wrSel | rdSel | ~cpuPending) begin
            starveCnt <= '0;
        end else if (rendSel && (starveCnt < STARVE_MAX)) begin
            starveCnt <= starveCnt + STV_W'(1);
        end
    end

    // Read-return flags, one cycle after the matching RAM read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            c_rvalid <= 1'b0;
        end else begin
            r_valid  <= rendSel;
            c_rvalid <= rdSel;
        end
    end

    // Return data is the RAM output, zeroed when not valid.
    always_comb begin
        r_data  = r_valid  ? m_rdata : '0;
        c_rdata = c_rvalid ? m_rdata : '0;
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: behavioural RAM plus a queue-based reference model.
module tb_vram_arbiter;

    localparam int unsigned AW     = 12;
    localparam int unsigned DW     = 16;
    localparam int unsigned STARVE = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          r_req;
    logic [AW-1:0] r_addr;
    logic          r_gnt;
    logic          r_valid;
    logic [DW-1:0] r_data;
    logic          c_req;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic          c_gnt;
    logic          c_rvalid;
    logic [DW-1:0] c_rdata;
    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    vram_arbiter #(.AW(AW), .DW(DW), .STARVE(STARVE)) dut (
        .clk(clk), .rst(rst),
        .r_req(r_req), .r_addr(r_addr), .r_gnt(r_gnt), .r_valid(r_valid), .r_data(r_data),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with one-cycle read latency.
    logic [DW-1:0] ram [2**AW];
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) ram[m_addr] <= m_wdata;
            else      m_rdata     <= ram[m_addr];
        end
    end

    // Reference model state.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           wq[$];
    logic [DW-1:0] shadow [2**AW];
    int            starve;
    bit            pendR, pendC;
    logic [DW-1:0] pendRData, pendCData;
    bit            lastExpCg;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of checking against the model; inputs are already applied.
    task automatic step();
        int cnt;
        bit cp, rend, wr, rd, push;
        bit nR, nC;
        logic [DW-1:0] nRData, nCData;
        @(negedge clk);
        if (rst) begin
            wq.delete();
            starve = 0;
            pendR  = 0;
            pendC  = 0;
        end
        chk("r_valid",  32'(r_valid),  32'(pendR));
        chk("r_data",   32'(r_data),   pendR ? 32'(pendRData) : 32'd0);
        chk("c_rvalid", 32'(c_rvalid), 32'(pendC));
        chk("c_rdata",  32'(c_rdata),  pendC ? 32'(pendCData) : 32'd0);

        cnt  = wq.size();
        cp   = (cnt > 0) || (c_req && !c_we);
        rend = !rst && r_req && ((starve < int'(STARVE)) || !cp);
        wr   = !rst && !rend && (cnt > 0);
        rd   = !rst && !rend && !wr && c_req && !c_we;
        push = !rst && c_req && c_we && (cnt < 2);
        lastExpCg = push || rd;

        chk("r_gnt", 32'(r_gnt), 32'(rend));
        chk("c_gnt", 32'(c_gnt), 32'(push || rd));
        chk("m_en",  32'(m_en),  32'(rend || wr || rd));
        chk("m_we",  32'(m_we),  32'(wr));
        if (rend) chk("m_addr_r", 32'(m_addr), 32'(r_addr));
        if (rd)   chk("m_addr_c", 32'(m_addr), 32'(c_addr));
        if (wr) begin
            chk("m_addr_w", 32'(m_addr),  32'(wq[0].addr));
            chk("m_wdata",  32'(m_wdata), 32'(wq[0].data));
        end

        nR = rend; nRData = shadow[r_addr];
        nC = rd;   nCData = shadow[c_addr];
        if (wr) begin
            shadow[wq[0].addr] = wq[0].data;
            void'(wq.pop_front());
        end
        if (push) wq.push_back('{addr: c_addr, data: c_wdata});
        if (wr || rd || !cp)                   starve = 0;
        else if (rend && starve < int'(STARVE)) starve++;

        @(posedge clk);
        #1;
        if (!rst) begin
            pendR = nR; pendRData = nRData;
            pendC = nC; pendCData = nCData;
        end
    endtask

    task automatic idleIn();
        r_req = 0; r_addr = '0; c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    endtask

    initial begin
        logic [DW-1:0] old40, old41;
        int n;
        for (int i = 0; i < 2**AW; i++) begin
            ram[i]    = DW'($urandom);
            shadow[i] = ram[i];
        end
        m_rdata = '0;
        starve = 0; pendR = 0; pendC = 0; pendRData = '0; pendCData = '0;
        idleIn();
        rst = 1;
        @(posedge clk); #1;
        step();
        rst = 0;

        // Renderer streaming reads.
        for (int i = 0; i < 4; i++) begin
            r_req = 1; r_addr = AW'(12'h010 + i);
            step();
        end
        idleIn();
        step();

        // Posted write under continuous renderer traffic.
        r_req = 1; r_addr = AW'(12'h100);
        c_req = 1; c_we = 1; c_addr = AW'(12'h020); c_wdata = 16'hBEEF;
        step();
        c_req = 0;
        for (int i = 0; i < 8; i++) begin
            r_addr = AW'(12'h101 + i);
            step();
        end
        chk("req039_ram", 32'(ram[12'h020]), 32'h0000BEEF);
        idleIn();
        step();

        // Three back-to-back writes: third must wait for a free entry.
        r_req = 1; r_addr = AW'(12'h200);
        for (int i = 0; i < 3; i++) begin
            c_req = 1; c_we = 1; c_addr = AW'(12'h050 + i); c_wdata = DW'(16'hA000 + i);
            n = 0;
            do begin
                step();
                n++;
            end while (!lastExpCg && n < 12);
            chk("req040_accept", 32'(lastExpCg), 32'd1);
        end
        c_req = 0;
        for (int i = 0; i < 10; i++) step();
        idleIn();
        step();

        // Read-after-write must wait for the buffered write to drain.
        c_req = 1; c_we = 1; c_addr = AW'(12'h030); c_wdata = 16'h1234;
        step();
        c_we = 0; c_wdata = '0;
        n = 0;
        do begin
            step();
            n++;
        end while (!lastExpCg && n < 6);
        chk("req041_rvalid", 32'(c_rvalid), 32'd1);
        chk("req041_rdata",  32'(c_rdata),  32'h00001234);
        idleIn();
        step();

        // Reset with two writes still buffered.
        old40 = ram[12'h040]; old41 = ram[12'h041];
        r_req = 1; r_addr = AW'(12'h300);
        c_req = 1; c_we = 1; c_addr = AW'(12'h040); c_wdata = 16'h5555;
        step();
        c_addr = AW'(12'h041); c_wdata = 16'h6666;
        step();
        idleIn();
        rst = 1;
        step();
        rst = 0;
        for (int i = 0; i < 3; i++) step();
        chk("req042_ram40", 32'(ram[12'h040]), 32'(old40));
        chk("req042_ram41", 32'(ram[12'h041]), 32'(old41));
        // First eligible request after reset is granted immediately.
        c_req = 1; c_we = 0; c_addr = AW'(12'h041);
        step();
        chk("req037_gnt", 32'(lastExpCg), 32'd1);
        idleIn();
        step();

        // Randomized traffic over a small address window.
        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom_range(0, 79) == 0);
            r_req   = ($urandom_range(0, 99) < 60);
            r_addr  = AW'($urandom_range(0, 15));
            c_req   = ($urandom_range(0, 99) < 50);
            c_we    = ($urandom_range(0, 1) == 1);
            c_addr  = AW'($urandom_range(0, 15));
            c_wdata = DW'($urandom);
            step();
        end
        rst = 0;
        idleIn();
        for (int i = 0; i < 12; i++) step();
        for (int i = 0; i < 16; i++) chk("final_ram", 32'(ram[i]), 32'(shadow[i]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
